xlr_mem_responder: RTL and testbench

Memory-side responder for the accelerator memory interface. It is a synthesizable banked SRAM model that serves accelerator-issued per-bank read and write requests with fixed read latency. A secondary host port, valid/ready, preloads and dumps bank contents, with lower priority than the accelerator. It sits between the accelerator's memory master ports and the SoC/testbench, giving HoneyB a closed-loop RTL memory in place of the UVM memory agent.

---
 rtl/xlr_mem_pkg.sv | 31 +++
 rtl/xlr_mem_responder_if.sv | 55 +++++
 rtl/xlr_mem_bank.sv | 117 +++++++++++
 rtl/xlr_mem_responder.sv | 115 +++++++++++
 tb/tb_xlr_mem_responder.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xlr_mem_pkg.sv
// Shared constants and line/byte-enable/address types for the accelerator memory responder.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
//
// Optional feature macro: XLR_MEM_RSP_PARITY_EN. When it is defined, byte_parity() supplies
// the per-byte even-parity bits.
package xlr_mem_pkg;

    localparam int NUM_MEMS           = 4;
    localparam int LOG2_LINES_PER_MEM = 8;
    localparam int MEM_DATA_WIDTH     = 256;
    localparam int MEM_BYTES          = MEM_DATA_WIDTH / 8;
    localparam int MEM_LINES          = 1 << LOG2_LINES_PER_MEM;
    localparam int MEM_SEL_W          = $clog2(NUM_MEMS);

    typedef logic [MEM_DATA_WIDTH-1:0]     mem_line_t;
    typedef logic [MEM_BYTES-1:0]          mem_be_t;
    typedef logic [LOG2_LINES_PER_MEM-1:0] mem_addr_t;
    typedef logic [MEM_SEL_W-1:0]          mem_sel_t;
    typedef logic [NUM_MEMS-1:0]           mem_vec_t;

    // Returns one even-parity bit per byte of a line.
    function automatic mem_be_t byte_parity(input mem_line_t d);
        mem_be_t p;
        for (int i = 0; i < MEM_BYTES; i++) begin
            p[i] = ^d[i*8 +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/xlr_mem_responder_if.sv
// Bundle of the per-bank accelerator memory ports and the single host preload/dump port.
// Latency: n/a (wiring only).
// Backpressure: the host port is valid/ready; the accelerator ports have no backpressure.
//
// Modports: slave = memory responder side, master = accelerator/host driver side.
// Optional feature macro: XLR_MEM_RSP_PARITY_EN adds inject_par_err and parity_err.
interface xlr_mem_responder_if;
    import xlr_mem_pkg::*;

    mem_addr_t [NUM_MEMS-1:0] mem_addr;
    mem_vec_t                 mem_rd;
    mem_vec_t                 mem_wr;
    mem_line_t [NUM_MEMS-1:0] mem_wdata;
    mem_be_t   [NUM_MEMS-1:0] mem_be;
    mem_line_t [NUM_MEMS-1:0] mem_rdata;
    mem_vec_t                 mem_rvalid;

    logic                     host_req_valid;
    logic                     host_req_ready;
    logic                     host_req_wr;
    mem_sel_t                 host_req_mem;
    mem_addr_t                host_req_addr;
    mem_line_t                host_req_wdata;
    logic                     host_rsp_valid;
    mem_line_t                host_rsp_rdata;
    logic                     host_starved;
    mem_vec_t                 collision_err;
`ifdef XLR_MEM_RSP_PARITY_EN
    mem_vec_t                 inject_par_err;
    mem_vec_t                 parity_err;
`endif

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata, mem_be,
        input  host_req_valid, host_req_wr, host_req_mem, host_req_addr, host_req_wdata,
`ifdef XLR_MEM_RSP_PARITY_EN
        input  inject_par_err,
        output parity_err,
`endif
        output mem_rdata, mem_rvalid, host_req_ready, host_rsp_valid, host_rsp_rdata,
        output host_starved, collision_err
    );

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata, mem_be,
        output host_req_valid, host_req_wr, host_req_mem, host_req_addr, host_req_wdata,
`ifdef XLR_MEM_RSP_PARITY_EN
        output inject_par_err,
        input  parity_err,
`endif
        input  mem_rdata, mem_rvalid, host_req_ready, host_rsp_valid, host_rsp_rdata,
        input  host_starved, collision_err
    );

endinterface

// File: rtl/xlr_mem_bank.sv
// One SRAM bank: byte-enabled write, read-before-write, accelerator read pipeline.
// Latency: accelerator read RD_LATENCY cycles; host read 1 cycle; write commits at the sampling edge.
// Backpressure: none; the top arbitrates so only one owner drives the bank per cycle.
//
// Ports: addr/rd_en/rd_host/wr_en/wdata/be request side; acc_* and host_* read returns.
// Optional feature macro: XLR_MEM_RSP_PARITY_EN adds inject_par_err and parity_err.
module xlr_mem_bank
    import xlr_mem_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  mem_addr_t addr,
    input  logic      rd_en,
    input  logic      rd_host,
    input  logic      wr_en,
    input  mem_line_t wdata,
    input  mem_be_t   be,
`ifdef XLR_MEM_RSP_PARITY_EN
    input  logic      inject_par_err,
    output logic      parity_err,
`endif
    output logic      acc_rvalid,
    output mem_line_t acc_rdata,
    output logic      host_rvalid,
    output mem_line_t host_rdata
);

    mem_line_t mem [MEM_LINES];
    mem_line_t rd_line;
    logic      acc_rd;
    logic      host_rd;
    logic      wr_arm;

    logic      [RD_LATENCY-1:0] pipe_vld;
    mem_line_t                  pipe_dat [RD_LATENCY];

    assign rd_line = mem[addr];
    assign acc_rd  = rd_en & ~rd_host;
    assign host_rd = rd_en & rd_host;

    // wr_arm drops asynchronously with rst, so no edge seen while rst is high can commit a
    // write; it re-arms on the first edge after release, which itself writes nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_arm <= 1'b0;
        end else begin
            wr_arm <= 1'b1;
        end
    end

    // Array is deliberately not reset. Nonblocking update gives read-before-write on a
    // same-edge read of the same line.
    always_ff @(posedge clk) begin
        if (wr_en && wr_arm) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Data stages only load on a valid entry, so the last stage holds its value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld    <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                pipe_dat[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= acc_rd;
            if (acc_rd) begin
                pipe_dat[0] <= rd_line;
            end
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                if (pipe_vld[s-1]) begin
                    pipe_dat[s] <= pipe_dat[s-1];
                end
            end
            host_rvalid <= host_rd;
            if (host_rd) begin
                host_rdata <= rd_line;
            end
        end
    end

    assign acc_rvalid = pipe_vld[RD_LATENCY-1];
    assign acc_rdata  = pipe_dat[RD_LATENCY-1];

`ifdef XLR_MEM_RSP_PARITY_EN
    mem_be_t par_mem [MEM_LINES];

    always_ff @(posedge clk) begin
        if (wr_en && wr_arm) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                if (be[i]) begin
                    par_mem[addr][i] <= (^wdata[i*8 +: 8]) ^ inject_par_err;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (rd_en && (byte_parity(rd_line) != par_mem[addr])) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/xlr_mem_responder.sv
// Banked SRAM responder: accelerator per-bank read/write plus a lower-priority host port.
// Latency: accelerator read RD_LATENCY cycles (1..4); host read 1 cycle; writes commit at the accepting edge.
// Backpressure: host_req_ready drops combinationally while the accelerator touches the host's bank.
//
// Ports: clk, rst (async active-high), bus (xlr_mem_responder_if.slave): mem_* accelerator
// ports, host_req_* / host_rsp_* host port, host_starved, collision_err.
// Optional feature macro: XLR_MEM_RSP_PARITY_EN (per-byte parity, parity_err, inject_par_err).
module xlr_mem_responder
    import xlr_mem_pkg::*;
#(
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                clk,
    input  logic                rst,
    xlr_mem_responder_if.slave  bus
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    mem_vec_t                 acc_busy;
    mem_vec_t                 acc_rvld;
    mem_line_t [NUM_MEMS-1:0] acc_rdat;
    mem_vec_t                 host_rvld;
    mem_line_t                host_rdat [NUM_MEMS];
    mem_sel_t                 rsp_mem;
    mem_vec_t                 collision;
    logic [STARVE_W-1:0]      starve_cnt;
`ifdef XLR_MEM_RSP_PARITY_EN
    mem_vec_t                 par_err;
`endif

    // The accelerator always owns its bank; the host only proceeds on an untouched bank.
    assign acc_busy           = bus.mem_rd | bus.mem_wr;
    assign bus.host_req_ready = bus.host_req_valid & ~acc_busy[bus.host_req_mem];

    for (genvar b = 0; b < NUM_MEMS; b++) begin : g_bank
        logic      host_hit;
        logic      host_rd;
        logic      host_wr;
        mem_addr_t addr;
        mem_line_t wdata;
        mem_be_t   be;

        assign host_hit = bus.host_req_ready && (bus.host_req_mem == mem_sel_t'(b));
        assign host_rd  = host_hit & ~bus.host_req_wr;
        assign host_wr  = host_hit & bus.host_req_wr;
        assign addr     = acc_busy[b] ? bus.mem_addr[b]  : bus.host_req_addr;
        assign wdata    = acc_busy[b] ? bus.mem_wdata[b] : bus.host_req_wdata;
        assign be       = acc_busy[b] ? bus.mem_be[b]    : '1;

        xlr_mem_bank #(
            .RD_LATENCY (RD_LATENCY)
        ) u_bank (
            .clk            (clk),
            .rst            (rst),
            .addr           (addr),
            .rd_en          (bus.mem_rd[b] | host_rd),
            .rd_host        (host_rd),
            .wr_en          (bus.mem_wr[b] | host_wr),
            .wdata          (wdata),
            .be             (be),
`ifdef XLR_MEM_RSP_PARITY_EN
            .inject_par_err (bus.inject_par_err[b]),
            .parity_err     (par_err[b]),
`endif
            .acc_rvalid     (acc_rvld[b]),
            .acc_rdata      (acc_rdat[b]),
            .host_rvalid    (host_rvld[b]),
            .host_rdata     (host_rdat[b])
        );
    end

    assign bus.mem_rvalid = acc_rvld;
    assign bus.mem_rdata  = acc_rdat;
`ifdef XLR_MEM_RSP_PARITY_EN
    assign bus.parity_err = par_err;
`endif

    // Remembers which bank answers the outstanding host read; at most one is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_mem <= '0;
        end else if (bus.host_req_ready && !bus.host_req_wr) begin
            rsp_mem <= bus.host_req_mem;
        end
    end

    assign bus.host_rsp_valid = |host_rvld;
    assign bus.host_rsp_rdata = host_rdat[rsp_mem];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision <= '0;
        end else begin
            collision <= collision | (bus.mem_rd & bus.mem_wr);
        end
    end

    assign bus.collision_err = collision;

    // Counts consecutive refused cycles of a pending host request, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.host_req_valid || bus.host_req_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    assign bus.host_starved = (starve_cnt == STARVE_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_xlr_mem_responder.sv
// Self-checking bench for xlr_mem_responder: directed scenarios plus a random phase,
// compared against a line-array reference model with due-cycle read slots.
module tb_xlr_mem_responder;
    import xlr_mem_pkg::*;

    localparam int RDL  = 3;
    localparam int SLIM = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xlr_mem_responder_if bus();

    xlr_mem_responder #(
        .RD_LATENCY   (RDL),
        .STARVE_LIMIT (SLIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    mem_line_t mm      [NUM_MEMS][MEM_LINES];
    bit        pend_v  [NUM_MEMS][8];
    mem_line_t pend_d  [NUM_MEMS][8];
    mem_line_t last_rd [NUM_MEMS];
    bit        hrsp_exp;
    mem_line_t hrsp_dat;
    int        wait_cnt;
    mem_vec_t  coll_exp;
    int        edge_n;

    task automatic check(input string tag, input mem_line_t obs, input mem_line_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic mem_line_t rand_line();
        mem_line_t d;
        for (int k = 0; k < MEM_DATA_WIDTH / 32; k++) begin
            d[k*32 +: 32] = $urandom();
        end
        return d;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NUM_MEMS; b++) begin
            last_rd[b] = '0;
            for (int s = 0; s < 8; s++) pend_v[b][s] = 1'b0;
        end
        hrsp_exp = 1'b0;
        wait_cnt = 0;
        coll_exp = '0;
    endtask

    task automatic drive_idle();
        bus.mem_rd         = '0;
        bus.mem_wr         = '0;
        bus.host_req_valid = 1'b0;
    endtask

    task automatic acc_op(input int b, input bit rd, input bit wr, input mem_addr_t a,
                          input mem_line_t d, input mem_be_t be);
        bus.mem_rd[b]    = rd;
        bus.mem_wr[b]    = wr;
        bus.mem_addr[b]  = a;
        bus.mem_wdata[b] = d;
        bus.mem_be[b]    = be;
    endtask

    task automatic host_op(input bit wr, input int b, input mem_addr_t a, input mem_line_t d);
        bus.host_req_valid = 1'b1;
        bus.host_req_wr    = wr;
        bus.host_req_mem   = mem_sel_t'(b);
        bus.host_req_addr  = a;
        bus.host_req_wdata = d;
    endtask

    // One clock: check ready, apply the edge to the model, then check all outputs.
    task automatic step();
        logic      ready_exp;
        int        hb;
        bit        exp_v;
        #1;
        hb = int'(bus.host_req_mem);
        ready_exp = bus.host_req_valid && !bus.mem_rd[hb] && !bus.mem_wr[hb];
        check("host_req_ready", mem_line_t'(bus.host_req_ready), mem_line_t'(ready_exp));
        @(posedge clk);
        edge_n++;
        for (int b = 0; b < NUM_MEMS; b++) begin
            if (bus.mem_rd[b]) begin
                pend_v[b][(edge_n + RDL - 1) % 8] = 1'b1;
                pend_d[b][(edge_n + RDL - 1) % 8] = mm[b][bus.mem_addr[b]];
            end
        end
        coll_exp = coll_exp | (bus.mem_rd & bus.mem_wr);
        hrsp_exp = 1'b0;
        if (ready_exp) begin
            if (bus.host_req_wr) begin
                mm[hb][bus.host_req_addr] = bus.host_req_wdata;
            end else begin
                hrsp_exp = 1'b1;
                hrsp_dat = mm[hb][bus.host_req_addr];
            end
        end
        for (int b = 0; b < NUM_MEMS; b++) begin
            if (bus.mem_wr[b]) begin
                for (int i = 0; i < MEM_BYTES; i++) begin
                    if (bus.mem_be[b][i]) mm[b][bus.mem_addr[b]][i*8 +: 8] = bus.mem_wdata[b][i*8 +: 8];
                end
            end
        end
        if (!bus.host_req_valid || ready_exp) wait_cnt = 0;
        else if (wait_cnt < SLIM) wait_cnt++;
        @(negedge clk);
        for (int b = 0; b < NUM_MEMS; b++) begin
            exp_v = pend_v[b][edge_n % 8];
            if (exp_v) last_rd[b] = pend_d[b][edge_n % 8];
            pend_v[b][edge_n % 8] = 1'b0;
            check($sformatf("mem_rvalid[%0d]", b), mem_line_t'(bus.mem_rvalid[b]), mem_line_t'(exp_v));
            check($sformatf("mem_rdata[%0d]", b), bus.mem_rdata[b], last_rd[b]);
        end
        check("host_rsp_valid", mem_line_t'(bus.host_rsp_valid), mem_line_t'(hrsp_exp));
        if (hrsp_exp) check("host_rsp_rdata", bus.host_rsp_rdata, hrsp_dat);
        check("host_starved", mem_line_t'(bus.host_starved), mem_line_t'(wait_cnt == SLIM));
        check("collision_err", mem_line_t'(bus.collision_err), mem_line_t'(coll_exp));
    endtask

    task automatic idle_steps(input int n);
        drive_idle();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        mem_line_t a5;
        mem_line_t l11;
        mem_line_t l22;
        mem_line_t d5a;
        mem_line_t d5h;
        mem_line_t keep;
        a5  = {32{8'hA5}};
        l11 = {32{8'h11}};
        l22 = {32{8'h22}};

        rst = 1'b1;
        edge_n = 0;
        model_reset();
        drive_idle();
        bus.mem_addr       = '0;
        bus.mem_wdata      = '0;
        bus.mem_be         = '0;
        bus.host_req_wr    = 1'b0;
        bus.host_req_mem   = '0;
        bus.host_req_addr  = '0;
        bus.host_req_wdata = '0;
`ifdef XLR_MEM_RSP_PARITY_EN
        bus.inject_par_err = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        // Reset state
        for (int b = 0; b < NUM_MEMS; b++) begin
            check("rst_rvalid", mem_line_t'(bus.mem_rvalid[b]), '0);
            check("rst_rdata", bus.mem_rdata[b], '0);
        end
        check("rst_host_rsp_valid", mem_line_t'(bus.host_rsp_valid), '0);
        check("rst_host_rsp_rdata", bus.host_rsp_rdata, '0);
        check("rst_starved", mem_line_t'(bus.host_starved), '0);
        check("rst_collision", mem_line_t'(bus.collision_err), '0);
        rst = 1'b0;
        step();

        // Preload lines 0..7 of every bank through the host port
        for (int b = 0; b < NUM_MEMS; b++) begin
            for (int l = 0; l < 8; l++) begin
                host_op(1'b1, b, mem_addr_t'(l), rand_line());
                step();
            end
        end
        drive_idle();

        // 1: host write A5 line, accelerator read returns after RDL cycles
        host_op(1'b1, 2, 8'h10, a5);
        step();
        drive_idle();
        acc_op(2, 1'b1, 1'b0, 8'h10, '0, '0);
        step();
        idle_steps(RDL - 1);
        check("t1_rdata", bus.mem_rdata[2], a5);

        // 2: byte-enabled write over zero line
        host_op(1'b1, 0, 8'd5, '0);
        step();
        drive_idle();
        acc_op(0, 1'b0, 1'b1, 8'd5, '1, mem_be_t'(32'h0000_000F));
        step();
        drive_idle();
        acc_op(0, 1'b1, 1'b0, 8'd5, '0, '0);
        step();
        idle_steps(RDL - 1);
        check("t2_rdata", bus.mem_rdata[0], mem_line_t'(32'hFFFF_FFFF));

        // 3: read and write same bank same cycle
        acc_op(1, 1'b0, 1'b1, 8'd7, l11, '1);
        step();
        acc_op(1, 1'b1, 1'b1, 8'd7, l22, '1);
        step();
        acc_op(1, 1'b1, 1'b0, 8'd7, '0, '0);
        step();
        idle_steps(1);
        check("t3_old", bus.mem_rdata[1], l11);
        idle_steps(1);
        check("t3_new", bus.mem_rdata[1], l22);
        check("t3_coll", mem_line_t'(bus.collision_err[1]), mem_line_t'(1'b1));

        // 4: host starvation while the accelerator holds bank 3
        host_op(1'b0, 3, 8'd3, '0);
        acc_op(3, 1'b1, 1'b0, 8'd0, '0, '0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == SLIM - 1) check("t4_not_yet", mem_line_t'(bus.host_starved), '0);
            if (i == SLIM) check("t4_starved", mem_line_t'(bus.host_starved), mem_line_t'(1'b1));
        end
        bus.mem_rd[3] = 1'b0;
        keep = mm[3][3];
        step();
        drive_idle();
        check("t4_unstarved", mem_line_t'(bus.host_starved), '0);
        check("t4_rsp_valid", mem_line_t'(bus.host_rsp_valid), mem_line_t'(1'b1));
        check("t4_rsp_data", bus.host_rsp_rdata, keep);
        idle_steps(RDL);

        // 5: host write bank 1 in parallel with accelerator write bank 0
        d5a = rand_line();
        d5h = rand_line();
        host_op(1'b1, 1, 8'h30, d5h);
        acc_op(0, 1'b0, 1'b1, 8'h30, d5a, '1);
        #1;
        check("t5_ready", mem_line_t'(bus.host_req_ready), mem_line_t'(1'b1));
        step();
        drive_idle();
        acc_op(0, 1'b1, 1'b0, 8'h30, '0, '0);
        acc_op(1, 1'b1, 1'b0, 8'h30, '0, '0);
        step();
        idle_steps(RDL - 1);
        check("t5_bank0", bus.mem_rdata[0], d5a);
        check("t5_bank1", bus.mem_rdata[1], d5h);

        // Random traffic over lines 0..7
        for (int n = 0; n < 300; n++) begin
            for (int b = 0; b < NUM_MEMS; b++) begin
                int r;
                r = $urandom_range(0, 7);
                acc_op(b, r < 3, (r >= 2) && (r < 5), mem_addr_t'($urandom_range(0, 7)),
                       rand_line(), mem_be_t'($urandom()));
            end
            if ($urandom_range(0, 1) == 1) begin
                host_op($urandom_range(0, 1) == 1, $urandom_range(0, NUM_MEMS - 1),
                        mem_addr_t'($urandom_range(0, 7)), rand_line());
            end else begin
                bus.host_req_valid = 1'b0;
            end
            step();
        end
        idle_steps(RDL + 1);

        // 6: reset mid-flight drops reads and blocks writes
        keep = rand_line();
        acc_op(1, 1'b0, 1'b1, 8'h20, keep, '1);
        step();
        drive_idle();
        acc_op(0, 1'b1, 1'b0, 8'd3, '0, '0);
        step();
        rst = 1'b1;
        acc_op(1, 1'b0, 1'b1, 8'h20, ~keep, '1);
        model_reset();
        #1;
        check("t6_coll_clear", mem_line_t'(bus.collision_err), '0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("t6_rvalid", mem_line_t'(bus.mem_rvalid), '0);
            check("t6_rdata0", bus.mem_rdata[0], '0);
            check("t6_starved", mem_line_t'(bus.host_starved), '0);
        end
        drive_idle();
        rst = 1'b0;
        step();
        acc_op(1, 1'b1, 1'b0, 8'h20, '0, '0);
        step();
        idle_steps(RDL - 1);
        check("t6_no_write", bus.mem_rdata[1], keep);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
